// File: rtl/rom_sma_pkg.sv
// Shared constants, types and the truth-table entry builder for the
// ROM-based sliced memory adder.
package rom_sma_pkg;

    localparam int NIB_W   = 4;
    localparam int ROM_LEN = 1 << (2 * NIB_W);

    // bit4 = slice carry out, bits3:0 = slice sum
    typedef logic [NIB_W:0] nib_sum_t;
    typedef nib_sum_t [ROM_LEN-1:0] rom_t;

    function automatic nib_sum_t build_entry(input logic [NIB_W-1:0] a,
                                             input logic [NIB_W-1:0] b,
                                             input logic             cin);
        return {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};
    endfunction

    function automatic rom_t build_rom(input logic cin);
        rom_t t;
        for (int i = 0; i < ROM_LEN; i++) begin
            t[i] = build_entry(NIB_W'(i >> NIB_W), NIB_W'(i), cin);
        end
        return t;
    endfunction

endpackage

// File: rtl/rom_sixteen_sma_adder_if.sv
// Operand/result bundle for the sliced memory adder; the adder is the slave.
interface rom_sixteen_sma_adder_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [DATA_WIDTH:0]   sum;

    modport master (output a, output b, input sum);
    modport slave  (input a, input b, output sum);
endinterface

// File: rtl/rom_sma_nibble_rom.sv
// One 4-bit adder slice: two constant truth tables (carry-in 0 and 1)
// addressed by {a_nib,b_nib}, with the carry-in choosing between them.
module rom_sma_nibble_rom
    import rom_sma_pkg::*;
(
    input  logic [NIB_W-1:0] a_nib,
    input  logic [NIB_W-1:0] b_nib,
    input  logic             cin,
    output nib_sum_t         nib_sum
);

    localparam rom_t T0 = build_rom(1'b0);
    localparam rom_t T1 = build_rom(1'b1);

    logic [2*NIB_W-1:0] idx;

    assign idx     = {a_nib, b_nib};
    assign nib_sum = cin ? T1[idx] : T0[idx];

endmodule

// File: rtl/rom_sixteen_sma_adder.sv
// Registered unsigned adder built from per-nibble ROM slices merged by
// carry-select; operands are registered on one edge, the sum on the next.
module rom_sixteen_sma_adder
    import rom_sma_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    rom_sixteen_sma_adder_if.slave  bus
);

    localparam int NSLICE = DATA_WIDTH / NIB_W;

    if ((DATA_WIDTH % NIB_W) != 0 || DATA_WIDTH < 4 || DATA_WIDTH > 32) begin : g_width_check
        $error("rom_sixteen_sma_adder: DATA_WIDTH=%0d must be a multiple of 4 in 4..32",
               DATA_WIDTH);
    end

    logic [DATA_WIDTH-1:0] a_reg;
    logic [DATA_WIDTH-1:0] b_reg;
    logic [DATA_WIDTH:0]   sum_reg;
    logic [DATA_WIDTH:0]   sum_next;
    logic [NSLICE:0]       carry;

    assign carry[0] = 1'b0;

    // Each slice picks its table from the previous slice's carry out.
    for (genvar i = 0; i < NSLICE; i++) begin : g_slice
        nib_sum_t slice_sum;

        rom_sma_nibble_rom u_rom (
            .a_nib   (a_reg[i*NIB_W +: NIB_W]),
            .b_nib   (b_reg[i*NIB_W +: NIB_W]),
            .cin     (carry[i]),
            .nib_sum (slice_sum)
        );

        assign sum_next[i*NIB_W +: NIB_W] = slice_sum[NIB_W-1:0];
        assign carry[i+1]                 = slice_sum[NIB_W];
    end

    assign sum_next[DATA_WIDTH] = carry[NSLICE];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            sum_reg <= '0;
        end else begin
            a_reg   <= bus.a;
            b_reg   <= bus.b;
            sum_reg <= sum_next;
        end
    end

    assign bus.sum = sum_reg;

endmodule

// File: tb/tb_rom_sixteen_sma_adder.sv
// Directed and exhaustive checks of the 8-bit ROM sliced memory adder,
// including asynchronous reset behaviour and pipeline flush.
module tb_rom_sixteen_sma_adder;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    rom_sixteen_sma_adder_if #(.DATA_WIDTH(W)) bus ();

    rom_sixteen_sma_adder #(.DATA_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [W:0] expq[$];
    string      tagq[$];

    task automatic checkOutput(input string tag, input logic [W:0] got, input logic [W:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d (%b) expected %0d (%b)", tag, got, got, exp, exp);
        end
    endtask

    // Results appear two edges after the drive, so the check for a vector
    // happens at the negedge where two newer vectors are already queued.
    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic [W:0] exp, input string tag);
        @(negedge clk);
        if (expq.size() == 2) checkOutput(tagq.pop_front(), bus.sum, expq.pop_front());
        bus.a = av;
        bus.b = bv;
        expq.push_back(exp);
        tagq.push_back(tag);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.a = '0;
        bus.b = '0;

        #1 rst = 1'b1;
        #1 checkOutput("reset_state", bus.sum, 9'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Test 1: asynchronous reset mid-operation
        applyStimulus(8'd200, 8'd100, 9'd300, "a200_b100_pre");
        applyStimulus(8'd200, 8'd100, 9'd300, "a200_b100_pre2");
        applyStimulus(8'd200, 8'd100, 9'd300, "a200_b100_pre3");
        @(posedge clk);
        #2 rst = 1'b1;
        #1 checkOutput("async_clear", bus.sum, 9'd0);
        expq.delete();
        tagq.delete();
        bus.a = 8'd7;
        bus.b = 8'd9;
        @(negedge clk);
        checkOutput("reset_hold_1", bus.sum, 9'd0);
        @(negedge clk);
        checkOutput("reset_hold_2", bus.sum, 9'd0);

        // Test 6: release between edges, first result two edges later
        #2 rst = 1'b0;
        #1 checkOutput("release_now", bus.sum, 9'd0);
        @(posedge clk);
        #1 checkOutput("release_edge1", bus.sum, 9'd0);
        @(posedge clk);
        #1 checkOutput("release_edge2", bus.sum, 9'd16);

        // Tests 2 and 3: directed vectors
        applyStimulus(8'd0,   8'd0,   9'b000000000, "a0_b0");
        applyStimulus(8'd3,   8'd5,   9'b000001000, "a3_b5");
        applyStimulus(8'd15,  8'd1,   9'b000010000, "a15_b1_nibble_carry");
        applyStimulus(8'd255, 8'd255, 9'b111111110, "a255_b255_max");
        applyStimulus(8'd255, 8'd1,   9'b100000000, "a255_b1_ripple");
        applyStimulus(8'd16,  8'd240, 9'b100000000, "a16_b240_upper_carry");
        applyStimulus(8'd136, 8'd120, 9'd256,       "a136_b120");

        // Test 4: every operand pair back-to-back
        for (int i = 0; i < 256; i++) begin
            for (int j = 0; j < 256; j++) begin
                applyStimulus(W'(i), W'(j), (W+1)'(i + j), $sformatf("pair_%0d_%0d", i, j));
            end
        end

        // Test 5: flush, then drain the two queued results
        applyStimulus(8'd0, 8'd0, 9'd0, "flush_1");
        applyStimulus(8'd0, 8'd0, 9'd0, "flush_2");
        applyStimulus(8'd0, 8'd0, 9'd0, "flush_3");
        applyStimulus(8'd0, 8'd0, 9'd0, "drain_1");
        applyStimulus(8'd0, 8'd0, 9'd0, "drain_2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
